// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: serializer states and line constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam logic        UART_IDLE_LVL  = 1'b1;
  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic [7:0]  ASCII_LF       = 8'h0A;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-producer bundle: per-requester valid/data with a one-hot ready back from the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: bit-timing divider, shift register and START/DATA/STOP sequencing.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       busy,
  output logic       sout
);

  localparam int unsigned DW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_e   state, state_d;
  logic [DW-1:0] div, div_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic          sout_d;
  logic          div_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      sout    <= UART_IDLE_LVL;
    end else begin
      state   <= state_d;
      div     <= div_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      sout    <= sout_d;
    end
  end

  assign busy     = (state != IDLE);
  assign div_last = (div == DIV_LAST);

  // Line level is computed for the next state so the pin itself is a flop.
  always_comb begin
    state_d   = state;
    div_d     = div;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    sout_d    = sout;
    case (state)
      IDLE: begin
        sout_d = UART_IDLE_LVL;
        if (load) begin
          state_d = START;
          div_d   = '0;
          shreg_d = load_data;
          sout_d  = 1'b0;
        end
      end
      START: begin
        if (div_last) begin
          state_d   = DATA;
          div_d     = '0;
          bit_idx_d = '0;
          sout_d    = shreg[0];
        end else begin
          div_d = div + 1'b1;
        end
      end
      DATA: begin
        if (div_last) begin
          div_d = '0;
          if (bit_idx == BIT_LAST) begin
            state_d = STOP;
            sout_d  = UART_IDLE_LVL;
          end else begin
            bit_idx_d = bit_idx + 1'b1;
            shreg_d   = {1'b0, shreg[7:1]};
            sout_d    = shreg[1];
          end
        end else begin
          div_d = div + 1'b1;
        end
      end
      STOP: begin
        if (div_last) begin
          state_d = IDLE;
          div_d   = '0;
        end else begin
          div_d = div + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 TX line among NUM_REQ byte producers.
// Optional per-requester line lock is built when UART_TX_LOCK_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned CLKS_PER_BIT   = 16,
  parameter int unsigned LOCK_IDLE_BITS = 64,
  localparam int unsigned GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_arbiter_if.slave    req,
  output logic                uart_sout,
  output logic                busy,
  output logic [GW-1:0]       grant_id
);

  logic [GW-1:0] ptr, win, cand;
  logic          found;
  logic [7:0]    sel_data;

`ifdef UART_TX_LOCK_EN
  localparam int unsigned LOCK_CYCLES = LOCK_IDLE_BITS * CLKS_PER_BIT;
  localparam int unsigned LW          = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] IDLE_LAST = LW'(LOCK_CYCLES - 1);

  logic          lock_active;
  logic [LW-1:0] idle_cnt;
`endif

  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((32'(ptr) + i) % NUM_REQ);
      if (!found && req.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
`ifdef UART_TX_LOCK_EN
    if (lock_active) begin
      win   = grant_id;
      found = req.req_valid[grant_id];
    end
`endif
    if (busy) found = 1'b0;
  end

  assign req.req_ready = found ? (NUM_REQ'(1) << win) : '0;
  assign sel_data      = req.req_data[8*win +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= GW'(NUM_REQ - 1);
      grant_id <= '0;
    end else if (found) begin
      ptr      <= win;
      grant_id <= win;
    end
  end

`ifdef UART_TX_LOCK_EN
  // An LF frame would release at its STOP bit; nothing is granted mid-frame,
  // so clearing the lock at acceptance of the LF is equivalent.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_active <= 1'b0;
      idle_cnt    <= '0;
    end else if (found) begin
      lock_active <= (sel_data != ASCII_LF);
      idle_cnt    <= '0;
    end else if (lock_active && !busy && !req.req_valid[grant_id]) begin
      if (idle_cnt == IDLE_LAST) begin
        lock_active <= 1'b0;
        idle_cnt    <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end else begin
      idle_cnt <= '0;
    end
  end
`endif

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (found),
    .load_data(sel_data),
    .busy     (busy),
    .sout     (uart_sout)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: arbitration model, serial-line scoreboard, corner sequences.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NR    = 3;
  localparam int CPB   = 4;
  localparam int LIB   = 64;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_sout;
  logic       busy;
  logic [1:0] grant_id;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ       (NR),
    .CLKS_PER_BIT  (CPB),
    .LOCK_IDLE_BITS(LIB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (bus),
    .uart_sout(uart_sout),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         grant;
  } exp_t;

  typedef struct {
    logic [2:0] valid;
    logic [7:0] data;
    int         grant;
  } vec_t;

  exp_t exp_q[$];
  int   hs_grant[$];
  int   hs_cyc[$];
  int   starts[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   hs_count = 0;

  // reference model state
  int         m_ptr  = NR - 1;
  int         m_busy = 0;
  int         w;
  logic [2:0] v;
  logic [7:0] hs_data;
`ifdef UART_TX_LOCK_EN
  int lock_on = 0;
  int m_owner = 0;
  int icnt    = 0;
`endif

  // serial monitor state
  int         mph       = 0;
  int         mcnt      = 0;
  int         mb;
  logic [7:0] mbyte;
  logic       prev_sout = 1'b1;
  exp_t       e;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [2:0] vv, input int ptr);
    for (int i = 1; i <= NR; i++)
      if (vv[(ptr + i) % NR]) return (ptr + i) % NR;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_ptr  = NR - 1;
      m_busy = 0;
      mph    = 0;
      exp_q.delete();
`ifdef UART_TX_LOCK_EN
      lock_on = 0;
      icnt    = 0;
`endif
    end else begin
      v = bus.req_valid;
      check("busy", busy, (m_busy > 0) ? 1 : 0);
      if (m_busy > 0) begin
        check("req_ready_busy", bus.req_ready, 0);
        m_busy--;
`ifdef UART_TX_LOCK_EN
        icnt = 0;
`endif
      end else begin
        w = rr_pick(v, m_ptr);
`ifdef UART_TX_LOCK_EN
        if (lock_on != 0) w = v[m_owner] ? m_owner : -1;
`endif
        check("req_ready", bus.req_ready, (w >= 0) ? (32'd1 << w) : 32'd0);
        if (w >= 0) begin
          hs_data = bus.req_data[8*w +: 8];
          exp_q.push_back('{data: hs_data, grant: w});
          hs_grant.push_back(w);
          hs_cyc.push_back(cyc);
          hs_count++;
          m_ptr  = w;
          m_busy = FRAME;
`ifdef UART_TX_LOCK_EN
          lock_on = (hs_data != 8'h0A) ? 1 : 0;
          m_owner = w;
          icnt    = 0;
`endif
        end
`ifdef UART_TX_LOCK_EN
        else if (lock_on != 0 && !v[m_owner]) begin
          icnt++;
          if (icnt == LIB * CPB) begin
            lock_on = 0;
            icnt    = 0;
          end
        end else begin
          icnt = 0;
        end
`endif
      end

      if (mph == 0) begin
        if (prev_sout && !uart_sout) begin
          mph  = 1;
          mcnt = 0;
          starts.push_back(cyc);
        end
      end else begin
        mcnt++;
      end
      if (mph == 1 && (mcnt % CPB) == CPB / 2) begin
        mb = mcnt / CPB;
        if (mb == 0) begin
          check("start_bit", uart_sout, 0);
        end else if (mb <= 8) begin
          mbyte[mb-1] = uart_sout;
        end else begin
          check("stop_bit", uart_sout, 1);
          mph = 0;
          check("sb_nonempty", (exp_q.size() != 0) ? 1 : 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rx_byte", mbyte, e.data);
            check("frame_grant", grant_id, e.grant);
          end
        end
      end
    end
    prev_sout = uart_sout;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nsamp();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst           = 1'b1;
    bus.req_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 4 * FRAME; t++) begin
      nsamp();
      if (!busy) break;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_hs();
    int n0;
    n0 = hs_count;
    for (int t = 0; t < 1000 && hs_count == n0; t++) nsamp();
    check("hs_timeout", (hs_count > n0) ? 1 : 0, 1);
  endtask

  task automatic set_data(input int r, input logic [7:0] d);
    bus.req_data[8*r +: 8] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[8];
    logic [7:0] pat;
    int         b;
    int         exp_order[6];

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (3) tick();
    rst = 1'b0;
    nsamp();
    check("rst_sout", uart_sout, 1);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_ready", bus.req_ready, 0);

`ifndef UART_TX_LOCK_EN
    // req0 sends 0x55 alone: exact line pattern and busy window
    tick();
    pat = 8'h55;
    set_data(0, pat);
    bus.req_valid = 3'b001;
    nsamp();
    check("a_ready", bus.req_ready, 3'b001);
    tick();
    bus.req_valid = '0;
    for (int k = 0; k < FRAME; k++) begin
      nsamp();
      b = k / CPB;
      check("a_sout", uart_sout, (b == 0) ? 0 : (b == 9) ? 1 : pat[b-1]);
      check("a_busy", busy, 1);
    end
    nsamp();
    check("a_busy_end", busy, 0);

    // pointer is now 0
    tbl[0] = '{valid: 3'b100, data: 8'hC0, grant: 2};
    tbl[1] = '{valid: 3'b101, data: 8'hB0, grant: 0};
    tbl[2] = '{valid: 3'b110, data: 8'h10, grant: 1};
    tbl[3] = '{valid: 3'b011, data: 8'h20, grant: 0};
    tbl[4] = '{valid: 3'b010, data: 8'h7E, grant: 1};
    tbl[5] = '{valid: 3'b010, data: 8'h81, grant: 1};
    tbl[6] = '{valid: 3'b111, data: 8'hE0, grant: 2};
    tbl[7] = '{valid: 3'b001, data: 8'h00, grant: 0};
    for (int i = 0; i < 8; i++) begin
      tick();
      for (int r = 0; r < NR; r++) set_data(r, tbl[i].data + 8'(r));
      bus.req_valid = tbl[i].valid;
      nsamp();
      check("tbl_ready", bus.req_ready, 32'd1 << tbl[i].grant);
      tick();
      bus.req_valid = '0;
      wait_idle();
      check("tbl_grant", grant_id, tbl[i].grant);
    end

    // all three streaming continuously
    do_reset();
    hs_grant.delete();
    hs_cyc.delete();
    starts.delete();
    tick();
    set_data(0, 8'h41);
    set_data(1, 8'h42);
    set_data(2, 8'h43);
    bus.req_valid = 3'b111;
    for (int t = 0; t < 8 * (FRAME + 1) && hs_grant.size() < 6; t++) nsamp();
    check("stream_hs_count", hs_grant.size(), 6);
    tick();
    bus.req_valid = '0;
    wait_idle();
    exp_order = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < 6 && i < hs_grant.size(); i++)
      check("stream_order", hs_grant[i], exp_order[i]);
    check("stream_starts", starts.size(), 6);
    for (int i = 1; i < starts.size(); i++)
      check("stream_spacing", starts[i] - starts[i-1], FRAME + 1);

    // reset during DATA bit 3 of 0xA5 (from req1, so grant_id is non-zero)
    tick();
    set_data(1, 8'hA5);
    bus.req_valid = 3'b010;
    wait_hs();
    tick();
    bus.req_valid = '0;
    repeat (17) tick();
    rst = 1'b1;
    nsamp();
    check("abort_bit3", uart_sout, 0);
    check("abort_grant_pre", grant_id, 1);
    tick();
    rst = 1'b0;
    nsamp();
    check("abort_sout", uart_sout, 1);
    check("abort_busy", busy, 0);
    check("abort_grant", grant_id, 0);

    // only req2 valid after reset, then req0+req2 wraps to req0
    tick();
    set_data(2, 8'h5A);
    bus.req_valid = 3'b100;
    nsamp();
    check("solo2_ready", bus.req_ready, 3'b100);
    tick();
    bus.req_valid = '0;
    wait_idle();
    check("solo2_grant", grant_id, 2);
    tick();
    set_data(0, 8'h3C);
    bus.req_valid = 3'b101;
    nsamp();
    check("wrap_ready", bus.req_ready, 3'b001);
    tick();
    bus.req_valid = '0;
    wait_idle();
    check("wrap_grant", grant_id, 0);
`else
    // req1 streams "hi\n" while req0 waits
    hs_grant.delete();
    hs_cyc.delete();
    tick();
    set_data(1, 8'h68);
    bus.req_valid = 3'b010;
    wait_hs();
    tick();
    set_data(0, 8'h30);
    set_data(1, 8'h69);
    bus.req_valid = 3'b011;
    wait_hs();
    tick();
    set_data(1, 8'h0A);
    wait_hs();
    tick();
    bus.req_valid = 3'b001;
    wait_hs();
    tick();
    bus.req_valid = '0;
    wait_idle();
    check("lf_hs_count", hs_grant.size(), 4);
    if (hs_grant.size() == 4) begin
      check("lf_g0", hs_grant[0], 1);
      check("lf_g1", hs_grant[1], 1);
      check("lf_g2", hs_grant[2], 1);
      check("lf_g3", hs_grant[3], 0);
      check("lf_gap", hs_cyc[3] - hs_cyc[2], FRAME + 1);
    end

    // req1 goes idle after "hi": release by inactivity timeout
    do_reset();
    hs_grant.delete();
    hs_cyc.delete();
    tick();
    set_data(1, 8'h68);
    bus.req_valid = 3'b010;
    wait_hs();
    tick();
    set_data(0, 8'h30);
    set_data(1, 8'h69);
    bus.req_valid = 3'b011;
    wait_hs();
    tick();
    bus.req_valid = 3'b001;
    wait_hs();
    tick();
    bus.req_valid = '0;
    wait_idle();
    check("to_hs_count", hs_grant.size(), 3);
    if (hs_grant.size() == 3) begin
      check("to_g2", hs_grant[2], 0);
      check("to_gap", hs_cyc[2] - hs_cyc[1], FRAME + LIB * CPB + 1);
    end
`endif

    repeat (4) nsamp();
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one 8N1 UART transmit line between NUM_REQ byte producers, e.g. core console writes, boot/debug message ROM and a test-status reporter. A round-robin arbiter accepts one byte per frame through a valid/ready handshake. The block owns the bit-timing divider and the serializer, so it fully sequences the serial line. Its uart_sout drives the SoC UART pin that the testbench serial monitor samples.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
CLKS_PER_BIT, 16, clk cycles per serial bit (>=2); counter width is $clog2(CLKS_PER_BIT)
LOCK_IDLE_BITS, 64, bit-times of owner inactivity that release a line lock (used only with UART_TX_LOCK_EN)

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  byte of requester i in [8*i+7:8*i]
req_ready  out  NUM_REQ  one-hot; byte accepted when valid&ready
uart_sout  out  1  serial TX line, idle high
busy  out  1  frame in progress
grant_id  out  $clog2(NUM_REQ) (min 1)  requester of the current or most recent frame

Behaviour:
- One clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset values: uart_sout=1, busy=0, grant_id=0, req_ready=0, FSM=IDLE. The round-robin pointer is set to NUM_REQ-1, so requester 0 has first priority.
- Reset mid-frame aborts the frame. uart_sout returns high on the next cycle and no byte is lost-signalled.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - req_ready is combinational: one-hot for the first valid requester searching upward from pointer+1 with wrap.
  - req_ready is zero when no requester is valid. It is always zero outside IDLE.
  - On a handshake: latch the byte into the shift register, set grant_id and pointer to the winner, clear the bit counter, go to START.
- START: uart_sout=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - A 3-bit index counts bits. Leave DATA after index 7 completes.
- STOP: uart_sout=1 for CLKS_PER_BIT cycles, then IDLE.
- Timing:
  - uart_sout is registered. The start bit appears the cycle after the handshake.
  - Back-to-back frames occupy 10*CLKS_PER_BIT+1 cycles, because of one IDLE cycle.
- busy = (state != IDLE). It is registered with the state.
- A requester dropping valid without a handshake has no effect.
- req_data is sampled only in the handshake cycle.
- With a single requester valid, that requester is granted every frame regardless of pointer.

Optional Feature:
UART_TX_LOCK_EN
- Defined:
  - After a grant, the arbiter locks to that requester; others see req_ready=0.
  - The lock releases when a byte 0x0A completes its STOP bit.
  - The lock also releases when the owner's req_valid stays low for LOCK_IDLE_BITS*CLKS_PER_BIT consecutive cycles while in IDLE.
  - Release makes round-robin resume from the owner.
  - A lock_active flag is internal only; no port change.
- Undefined: arbitration is pure per-byte round-robin and the lock logic is absent.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, STOP)
  - UART_IDLE_LVL=1'b1, UART_DATA_BITS=8, ASCII_LF=8'h0A
- Natural sub-module: uart_tx_serializer, which contains the FSM, divider and shift register. Its interface is a single load/busy handshake.
- The top level keeps the round-robin arbiter and the lock logic.

Test Plan:
- NUM_REQ=3, CLKS_PER_BIT=4; req0 sends 0x55 alone:
  - req_ready[0] in the same cycle.
  - uart_sout is 0 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles. busy is high for 40 cycles.
- All three valid continuously with bytes 0x41/0x42/0x43:
  - Grant order 0,1,2,0,1,2.
  - Each frame start is 41 cycles after the previous one.
- Only req2 valid after reset: granted immediately, grant_id=2. Then req0+req2 valid: next grant goes to req0 (wrap).
- rst asserted during the DATA bit 3 of 0xA5: next cycle uart_sout=1, busy=0, grant_id=0. The next request is accepted normally.
- With UART_TX_LOCK_EN: req1 streams "hi\n" while req0 is valid throughout.
  - req0 is blocked until 0x0A's stop bit ends, then granted.
  - Repeat with req1 going idle after "hi": req0 is granted after 64*4 idle cycles.
- Monitor sampling at CLKS_PER_BIT/2 within each bit reconstructs every accepted byte, in acceptance order.
